muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle sequencer for the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), placed in the EX stage beside the single-cycle ALU. The main controller routes R-type instructions with Funct7 = 7'b0000001 here instead of to the ALU operation decoder, and holds the pipeline while `busy` is high. The sequencer runs one radix-2 shift-add (multiply) or restoring-subtract (divide) step per cycle, then applies the sign fix-up. It returns a 32-bit result with a one-cycle `done` pulse.

## Interface
- XLEN, 32, operand/result width; iteration count equals XLEN
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only in IDLE
- Funct3  in  3  M-extension op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  in  XLEN  rs1 value (multiplicand / dividend)
- SrcB  in  XLEN  rs2 value (multiplier / divisor)
- flush  in  1  synchronous abort (pipeline flush)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, Result valid
- Result  out  XLEN  registered result; holds until the next accepted start

## Operation
- Reset values: state = IDLE, busy = 0, done = 0, Result = 0, all internal registers = 0.
- States are IDLE, CALC, FIX and DONE.
- **IDLE**
  - On start, latch Funct3 and the operands.
  - Compute absolute values for signed operands: MULH/DIV/REM treat both operands as signed; MULHSU treats only SrcA as signed.
  - Record the result sign. Product sign is signA XOR signB. Quotient sign is signA XOR signB. Remainder sign is signA.
  - Clear the step counter and go to CALC.
- **Divide special cases** are detected in IDLE at accept. They skip CALC and FIX and go directly to DONE with Result loaded:
  - Divide by zero (SrcB == 0): DIV/DIVU return all-ones; REM/REMU return SrcA.
  - Signed overflow (DIV/REM, SrcA = 0x80000000, SrcB = 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- **CALC** runs exactly XLEN cycles, one step per cycle.
  - Multiply: 2·XLEN-bit accumulator. Add the multiplicand if the multiplier LSB is set, then shift right.
  - Divide: partial remainder is XLEN+1 bits. Shift in the next dividend bit and trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit.
  - When the counter reaches XLEN-1, go to FIX.
- **FIX** (one cycle):
  - Negate the result if its sign flag is set.
  - MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits.
  - DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Register Result and go to DONE.
- **DONE** (one cycle): done = 1, then go to IDLE. A start seen in DONE is ignored.
- **flush**: any state goes to IDLE on the next edge. Result and internal registers are unchanged and done stays 0. flush has priority over start in IDLE and over done.
- **Async reset mid-operation**: immediately IDLE with all outputs at reset values. No done pulse for the aborted op.

## Timing
- The accept edge is cycle 0.
- Normal ops:
  - CALC occupies cycles 1..XLEN.
  - FIX is cycle XLEN+1.
  - done and Result are valid in cycle XLEN+2 (cycle 34 for XLEN = 32).
  - busy is high in cycles 1..XLEN+2.
- Special divide cases: done in cycle 1 and busy in cycle 1 only.
- Next start is accepted earliest in the cycle after done (back-to-back throughput: XLEN+3 cycles).
- No combinational path from inputs to outputs; busy, done and Result are all registered or derived from state.
- Operand or Funct3 changes while busy are ignored.

## Structure
- Package `muldiv_pkg` holds:
  - the `muldiv_state_e` enum (IDLE, CALC, FIX, DONE);
  - the `muldiv_op_e` enum for the Funct3 encodings;
  - the FUNCT7_MULDIV = 7'b0000001 constant.
- No sub-module is warranted: control FSM, counter and shared accumulator/remainder datapath stay in one module. The multiply and divide steps share the same shift register.

## Test plan
- MUL with SrcA = 7, SrcB = 0xFFFFFFFD -> done in cycle 34 with Result = 0xFFFFFFEB; busy high in cycles 1..34.
- MULHU with SrcA = SrcB = 0xFFFFFFFF -> Result = 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU with the same operands -> 0xFFFFFFFF.
- DIV with 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- Special cases, each with done in cycle 1:
  - DIVU 5 / 0 -> 0xFFFFFFFF.
  - REM 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- flush in cycle 10 of a DIV -> IDLE in cycle 11, no done pulse, Result unchanged. A new MUL started in cycle 11 completes in cycle 45.
- Assert rst_n low in cycle 20 of a MUL -> busy, done and Result are 0 immediately. After release, a start with no flush completes normally 34 cycles later.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int MULDIV_XLEN = 32;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

endpackage

// File: rtl/muldiv_sequencer.sv
// Radix-2 multi-cycle multiply/divide unit for RV32M; one shift-add or
// restoring-subtract step per cycle on a shared 2*XLEN shift register.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   LAST_STEP = CW'(XLEN - 1);

  muldiv_state_e   r_state;
  muldiv_op_e      r_op;
  logic [CW-1:0]   r_cnt;
  logic            r_neg;
  logic [XLEN-1:0] r_opb;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_result;
  logic            r_busy;
  logic            r_done;

  // Accept-time decode
  muldiv_op_e      w_op;
  logic            w_a_is_signed;
  logic            w_b_is_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_is_div;
  logic            w_is_rem;
  logic            w_sign;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;

  assign w_op          = muldiv_op_e'(Funct3);
  assign w_a_is_signed = (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                         (w_op == OP_DIV)  || (w_op == OP_REM);
  assign w_b_is_signed = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_a_neg       = w_a_is_signed & SrcA[XLEN-1];
  assign w_b_neg       = w_b_is_signed & SrcB[XLEN-1];
  assign w_abs_a       = w_a_neg ? -SrcA : SrcA;
  assign w_abs_b       = w_b_neg ? -SrcB : SrcB;
  assign w_is_div      = Funct3[2];
  assign w_is_rem      = Funct3[2] & Funct3[1];
  // Remainder follows the dividend's sign; product and quotient use the XOR.
  assign w_sign        = w_is_rem ? w_a_neg : (w_a_neg ^ w_b_neg);
  assign w_div_zero    = w_is_div && (SrcB == '0);
  assign w_div_ovf     = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                         (SrcA == INT_MIN) && (SrcB == '1);
  assign w_special     = w_div_zero | w_div_ovf;
  assign w_special_res = w_div_zero ? (w_is_rem ? SrcA : '1)
                                    : (w_is_rem ? '0 : INT_MIN);

  // Multiply step: acc = {hi, multiplier}; add multiplicand to hi, shift right.
  logic            w_r_is_div;
  logic [XLEN:0]   w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;

  assign w_r_is_div = (r_op == OP_DIV) || (r_op == OP_DIVU) ||
                      (r_op == OP_REM) || (r_op == OP_REMU);
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                      (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide step: acc = {remainder, dividend/quotient}; quotient bits enter at the LSB.
  logic [XLEN:0]   w_div_shift;
  logic [XLEN:0]   w_div_trial;
  logic            w_div_ok;
  logic [2*XLEN-1:0] w_div_next;

  assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_opb};
  assign w_div_ok    = ~w_div_trial[XLEN];
  assign w_div_next  = {(w_div_ok ? w_div_trial[XLEN-1:0] : w_div_shift[XLEN-1:0]),
                        r_acc[XLEN-2:0], w_div_ok};

  // Sign fix-up and result selection
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_fix_res;

  assign w_prod_fix = r_neg ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem_fix  = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      OP_MUL:                       w_fix_res = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_fix_res = w_quo_fix;
      default:                      w_fix_res = w_rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_op     <= OP_MUL;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_op   <= w_op;
              r_neg  <= w_sign;
              r_cnt  <= '0;
              r_opb  <= w_is_div ? w_abs_b : w_abs_a;
              r_acc  <= {{XLEN{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
              r_busy <= 1'b1;
              if (w_special) begin
                r_result <= w_special_res;
                r_state  <= DONE;
                r_done   <= 1'b1;
              end else begin
                r_state  <= CALC;
              end
            end
          end
          CALC: begin
            r_acc <= w_r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_STEP) begin
              r_state <= FIX;
            end
          end
          FIX: begin
            r_result <= w_fix_res;
            r_state  <= DONE;
            r_done   <= 1'b1;
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign Result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M vectors, special
// divide cases, flush and mid-operation reset, plus random operands.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  Funct3 = 3'd0;
  logic [31:0] SrcA = 32'd0;
  logic [31:0] SrcB = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] Result;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  logic [2:0]  rf;
  logic [31:0] ra, rb, saved;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .Funct3 (Funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .Result (Result)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ubs, p;
    logic [63:0] up;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ubs = {32'd0, b};
    up  = {32'd0, a} * {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: return up[31:0];
      3'd1: begin p = sa * sb;  return p[63:32]; end
      3'd2: begin p = sa * ubs; return p[63:32]; end
      3'd3: return up[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && ((b == 0) ||
        (((f == 3'd4) || (f == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))))
      return 1;
    return 34;
  endfunction

  // Called just after a negedge; returns just after the negedge following done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit poke_in_done);
    int lat;
    bit seen;
    logic [31:0] want;
    lat  = exp_lat(f, a, b);
    seen = 1'b0;
    exp_q.push_back(exp);
    Funct3 = f; SrcA = a; SrcB = b; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      start  = 1'b0;
      SrcA   = $urandom;
      SrcB   = $urandom;
      Funct3 = 3'($urandom_range(0, 7));
      check_eq("busy_while_running", 32'(busy), 32'd1);
      check_eq($sformatf("done_timing f%0d k%0d", f, k), 32'(done), 32'(k == lat));
      if (done) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          check_eq("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          want = exp_q.pop_front();
          check_eq($sformatf("result f%0d a%08h b%08h", f, a, b), Result, want);
        end
        if (poke_in_done) start = 1'b1;
      end
    end
    if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_done", 32'(busy), 32'd0);
    check_eq("done_after_done", 32'(done), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_result", Result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed multiply/divide vectors
    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0);
    run_op(3'd5, 32'd100,        32'd7,         32'd14,        1'b0);
    run_op(3'd7, 32'd100,        32'd7,         32'd2,         1'b1);

    // Special divide cases
    run_op(3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b0);
    run_op(3'd6, 32'd5,          32'd0,         32'd5,         1'b1);
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0);

    // Flush in cycle 10 of a DIV
    saved  = Result;
    Funct3 = 3'd4; SrcA = 32'd1000; SrcB = 32'd3; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      check_eq("flush_busy_pre", 32'(busy), 32'd1);
      check_eq("flush_done_pre", 32'(done), 32'd0);
      if (k == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_busy_post", 32'(busy), 32'd0);
    check_eq("flush_done_post", 32'(done), 32'd0);
    check_eq("flush_result_held", Result, saved);
    run_op(3'd0, 32'd12345, 32'd678, 32'd8369910, 1'b0);

    // Async reset in cycle 20 of a MUL
    Funct3 = 3'd0; SrcA = 32'd123; SrcB = 32'd456; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      check_eq("rst_busy_pre", 32'(busy), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    check_eq("rst_busy_now", 32'(busy), 32'd0);
    check_eq("rst_done_now", 32'(done), 32'd0);
    check_eq("rst_result_now", Result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_no_done", 32'(done), 32'd0);
    run_op(3'd0, 32'd123, 32'd456, 32'd56088, 1'b0);

    // Random operands against the reference model
    for (int i = 0; i < 16; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      case (i % 4)
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if (i % 5 == 2) ra = 32'h8000_0000;
      run_op(rf, ra, rb, model(rf, ra, rb), (i % 3) == 0);
    end

    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
